// File: rtl/div_entry_sequencer.sv
// Keypad divider sequencer: nibble entry of A and B, restoring divide, then bin2bcd handshake.
// Optional build macro DIV_CLEAR_KEY_EN makes key 4'hE a clear key while entering operands.
module div_entry_sequencer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [3:0]   key_hex,
   input  logic         bcd_done,
   output logic         bcd_start,
   output logic [W-1:0] a_val,
   output logic [W-1:0] b_val,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem,
   output logic         busy,
   output logic         done,
   output logic         div_zero,
   output logic         key_drop,
   output logic [2:0]   state_dbg
);

   localparam int NIB = W / 4;
   localparam int NCW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int IW  = $clog2(W);
   localparam logic [NCW-1:0] NIB_LAST  = NCW'(NIB - 1);
   localparam logic [IW-1:0]  ITER_LAST = IW'(W - 1);

   typedef enum logic [2:0] {
      CAP_A     = 3'd0,
      CAP_B     = 3'd1,
      DIVIDE    = 3'd2,
      BCD_START = 3'd3,
      BCD_WAIT  = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t state, state_next;

   logic [NCW-1:0] nib_cnt;
   logic [IW-1:0]  iter;
   logic [W-1:0]   p_reg;
   logic [W-1:0]   sh_reg;

   logic           accept;
   logic           is_clear;
   logic           nib_last;
   logic           first;
   logic           b_zero;
   logic [W-1:0]   p_cur;
   logic [W-1:0]   sh_cur;
   logic [W:0]     p_shift;
   logic [W:0]     p_diff;
   logic           q_bit;
   logic [W-1:0]   p_new;
   logic [W-1:0]   sh_new;

   assign accept   = key_valid && (key_hex != 4'hF);
`ifdef DIV_CLEAR_KEY_EN
   assign is_clear = (key_hex == 4'hE);
`else
   assign is_clear = 1'b0;
`endif
   assign nib_last = (nib_cnt == NIB_LAST);
   assign first    = (iter == '0);
   assign b_zero   = (b_val == '0);

   // Partial remainder stays below b_val, so W bits hold it between steps; the
   // borrow out of the W+1-bit trial subtraction is the inverted quotient bit.
   assign p_cur   = first ? '0 : p_reg;
   assign sh_cur  = first ? a_val : sh_reg;
   assign p_shift = {p_cur, sh_cur[W-1]};
   assign p_diff  = p_shift - {1'b0, b_val};
   assign q_bit   = ~p_diff[W];
   assign p_new   = q_bit ? p_diff[W-1:0] : p_shift[W-1:0];
   assign sh_new  = {sh_cur[W-2:0], q_bit};

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst) state <= CAP_A;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      bcd_start  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         CAP_A: begin
            if (accept && !is_clear && nib_last) state_next = CAP_B;
         end
         CAP_B: begin
            if (accept) begin
               if (is_clear)      state_next = CAP_A;
               else if (nib_last) state_next = DIVIDE;
            end
         end
         DIVIDE: begin
            busy = 1'b1;
            if ((first && b_zero) || (iter == ITER_LAST)) state_next = BCD_START;
         end
         BCD_START: begin
            busy       = 1'b1;
            bcd_start  = 1'b1;
            state_next = BCD_WAIT;
         end
         BCD_WAIT: begin
            busy = 1'b1;
            if (bcd_done) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (accept) state_next = (is_clear || NIB > 1) ? CAP_A : CAP_B;
         end
         default: state_next = CAP_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_val    <= '0;
         b_val    <= '0;
         quot     <= '0;
         rem      <= '0;
         div_zero <= 1'b0;
         key_drop <= 1'b0;
         nib_cnt  <= '0;
         iter     <= '0;
         p_reg    <= '0;
         sh_reg   <= '0;
      end else begin
         key_drop <= 1'b0;
         case (state)
            CAP_A, CAP_B: begin
               if (accept) begin
                  if (is_clear) begin
                     a_val   <= '0;
                     b_val   <= '0;
                     nib_cnt <= '0;
                  end else begin
                     if (state == CAP_A) a_val <= W'({a_val, key_hex});
                     else                b_val <= W'({b_val, key_hex});
                     nib_cnt <= nib_last ? '0 : nib_cnt + NCW'(1);
                  end
               end
            end
            DIVIDE: begin
               key_drop <= accept;
               if (first && b_zero) begin
                  quot     <= '0;
                  rem      <= a_val;
                  div_zero <= 1'b1;
               end else begin
                  if (first) div_zero <= 1'b0;
                  p_reg  <= p_new;
                  sh_reg <= sh_new;
                  if (iter == ITER_LAST) begin
                     quot <= sh_new;
                     rem  <= p_new;
                     iter <= '0;
                  end else begin
                     iter <= iter + IW'(1);
                  end
               end
            end
            BCD_START, BCD_WAIT: begin
               key_drop <= accept;
            end
            DONE: begin
               if (accept) begin
                  b_val <= '0;
                  if (is_clear) begin
                     a_val   <= '0;
                     nib_cnt <= '0;
                  end else begin
                     a_val   <= W'(key_hex);
                     nib_cnt <= (NIB > 1) ? NCW'(1) : '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_entry_sequencer.sv
// Directed self-checking bench for div_entry_sequencer (W=8).
module tb_div_entry_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         key_valid;
   logic [3:0]   key_hex;
   logic         bcd_done;
   logic         bcd_start;
   logic [W-1:0] a_val;
   logic [W-1:0] b_val;
   logic [W-1:0] quot;
   logic [W-1:0] rem;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic         key_drop;
   logic [2:0]   state_dbg;

   int checks = 0;
   int errors = 0;

   div_entry_sequencer #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_hex   (key_hex),
      .bcd_done  (bcd_done),
      .bcd_start (bcd_start),
      .a_val     (a_val),
      .b_val     (b_val),
      .quot      (quot),
      .rem       (rem),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .key_drop  (key_drop),
      .state_dbg (state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [3:0] k);
      key_valid = 1'b1;
      key_hex   = k;
      tick();
      key_valid = 1'b0;
      key_hex   = 4'hF;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (bcd_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic finish_bcd;
      bcd_done = 1'b1;
      tick();
      bcd_done = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      checks++; if ({a_val, b_val, quot, rem} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {a_val, b_val, quot, rem}); end
      checks++; if ({busy, done, div_zero, key_drop, bcd_start} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, div_zero, key_drop, bcd_start}); end
   endtask

   task automatic test_divide;
      int n;
      send_key(4'h6); send_key(4'h4); send_key(4'h0); send_key(4'h7);
      checks++; if (a_val !== 8'h64) begin errors++; $display("FAIL div_a_val: got %h expected 64", a_val); end
      checks++; if (b_val !== 8'h07) begin errors++; $display("FAIL div_b_val: got %h expected 07", b_val); end
      checks++; if ({state_dbg, busy} !== {3'd2, 1'b1}) begin errors++; $display("FAIL div_enter: got state %0d busy %b expected 2 1", state_dbg, busy); end
      wait_start(n);
      checks++; if (n !== 8) begin errors++; $display("FAIL div_latency: got %0d expected 8", n); end
      checks++; if (quot !== 8'h0E) begin errors++; $display("FAIL div_quot: got %h expected 0e", quot); end
      checks++; if (rem !== 8'h02) begin errors++; $display("FAIL div_rem: got %h expected 02", rem); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_zero_flag: got %b expected 0", div_zero); end
      tick();
      checks++; if ({bcd_start, state_dbg} !== {1'b0, 3'd4}) begin errors++; $display("FAIL start_pulse: got start %b state %0d expected 0 4", bcd_start, state_dbg); end
      repeat (3) tick();
      checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL bcd_wait_hold: got %0d expected 4", state_dbg); end
      finish_bcd();
      checks++; if ({done, busy, state_dbg} !== {1'b1, 1'b0, 3'd5}) begin errors++; $display("FAIL div_done: got done %b busy %b state %0d expected 1 0 5", done, busy, state_dbg); end
      checks++; if (quot !== 8'h0E) begin errors++; $display("FAIL done_quot_hold: got %h expected 0e", quot); end
   endtask

   task automatic test_div_zero;
      int n;
      send_key(4'h5); send_key(4'hA); send_key(4'h0); send_key(4'h0);
      checks++; if ({a_val, b_val} !== 16'h5A00) begin errors++; $display("FAIL dz_operands: got %h expected 5a00", {a_val, b_val}); end
      wait_start(n);
      checks++; if (n !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", n); end
      checks++; if ({quot, rem} !== 16'h005A) begin errors++; $display("FAIL dz_result: got %h expected 005a", {quot, rem}); end
      checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
      tick();
      finish_bcd();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done: got %b expected 1", done); end
   endtask

   task automatic test_idle_and_drop;
      int n;
      do_reset();
      send_key(4'hF); send_key(4'hF);
      checks++; if ({a_val, state_dbg, key_drop} !== {8'h00, 3'd0, 1'b0}) begin errors++; $display("FAIL idle_key: got a %h state %0d drop %b expected 00 0 0", a_val, state_dbg, key_drop); end
      send_key(4'h6); send_key(4'h4); send_key(4'h0); send_key(4'h7);
      send_key(4'h3);
      checks++; if ({key_drop, state_dbg} !== {1'b1, 3'd2}) begin errors++; $display("FAIL busy_drop: got drop %b state %0d expected 1 2", key_drop, state_dbg); end
      tick();
      checks++; if (key_drop !== 1'b0) begin errors++; $display("FAIL drop_width: got %b expected 0", key_drop); end
      send_key(4'hF);
      checks++; if (key_drop !== 1'b0) begin errors++; $display("FAIL idle_no_drop: got %b expected 0", key_drop); end
      wait_start(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL drop_latency: got %0d expected 5", n); end
      checks++; if ({quot, rem, a_val, b_val} !== 32'h0E026407) begin errors++; $display("FAIL drop_result: got %h expected 0e026407", {quot, rem, a_val, b_val}); end
      tick();
      key_valid = 1'b1; key_hex = 4'h5; bcd_done = 1'b1;
      tick();
      key_valid = 1'b0; key_hex = 4'hF; bcd_done = 1'b0;
      checks++; if ({state_dbg, key_drop, a_val} !== {3'd5, 1'b1, 8'h64}) begin errors++; $display("FAIL drop_at_done: got state %0d drop %b a %h expected 5 1 64", state_dbg, key_drop, a_val); end
   endtask

   task automatic test_done_restart;
      int n;
      send_key(4'h1);
      checks++; if ({state_dbg, a_val, b_val, done} !== {3'd0, 8'h01, 8'h00, 1'b0}) begin errors++; $display("FAIL restart: got state %0d a %h b %h done %b expected 0 01 00 0", state_dbg, a_val, b_val, done); end
      checks++; if ({quot, rem} !== 16'h0E02) begin errors++; $display("FAIL restart_keep: got %h expected 0e02", {quot, rem}); end
      send_key(4'h2); send_key(4'h0); send_key(4'h3);
      wait_start(n);
      checks++; if ({quot, rem, n[7:0]} !== 24'h060008) begin errors++; $display("FAIL restart_div: got %h expected 060008", {quot, rem, n[7:0]}); end
      tick();
      finish_bcd();
   endtask

   task automatic test_abort;
      int n;
      int seen;
      do_reset();
      send_key(4'h6); send_key(4'h4); send_key(4'h0); send_key(4'h7);
      repeat (3) tick();
      checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL abort_pre: got %0d expected 2", state_dbg); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if ({state_dbg, a_val, b_val, quot, rem} !== '0) begin errors++; $display("FAIL abort_data: got %h expected 0", {state_dbg, a_val, b_val, quot, rem}); end
      checks++; if ({busy, done, div_zero, key_drop, bcd_start} !== 5'b0) begin errors++; $display("FAIL abort_flags: got %b expected 00000", {busy, done, div_zero, key_drop, bcd_start}); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bcd_start === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_start: got %0d expected 0", seen); end
      send_key(4'h0); send_key(4'h9); send_key(4'h0); send_key(4'h3);
      wait_start(n);
      checks++; if ({quot, rem, n[7:0]} !== 24'h030008) begin errors++; $display("FAIL abort_redo: got %h expected 030008", {quot, rem, n[7:0]}); end
      tick();
      finish_bcd();
   endtask

   task automatic test_clear_key;
      int n;
      do_reset();
`ifdef DIV_CLEAR_KEY_EN
      send_key(4'h1); send_key(4'h2); send_key(4'hE);
      send_key(4'h4); send_key(4'h8); send_key(4'h0); send_key(4'h2);
      wait_start(n);
      checks++; if ({a_val, quot, rem} !== 24'h482400) begin errors++; $display("FAIL clear_key: got %h expected 482400", {a_val, quot, rem}); end
`else
      send_key(4'hE); send_key(4'hE); send_key(4'h0); send_key(4'h2);
      wait_start(n);
      checks++; if ({a_val, quot, rem} !== 24'hEE7700) begin errors++; $display("FAIL digit_e: got %h expected ee7700", {a_val, quot, rem}); end
`endif
      checks++; if (n !== 8) begin errors++; $display("FAIL e_latency: got %0d expected 8", n); end
      tick();
      finish_bcd();
   endtask

   initial begin
      rst       = 1'b0;
      key_valid = 1'b0;
      key_hex   = 4'hF;
      bcd_done  = 1'b0;
      test_reset();
      test_divide();
      test_div_zero();
      test_idle_and_drop();
      test_done_restart();
      test_abort();
      test_clear_key();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
